// File: rtl/ps_issue_reg_pkg.sv
// Shared definitions for the RS issue path: functional-unit classes and
// the number of FU classes that the per-class ready vector spans.
package ps_issue_reg_pkg;

   typedef enum logic [1:0] {
      ALU    = 2'd0,
      MULT   = 2'd1,
      LOAD   = 2'd2,
      BRANCH = 2'd3
   } FUNC_UNIT;

   localparam int NUM_FU_CLASS = 4;

endpackage

// File: rtl/ps_onehot_enc.sv
// One-hot to binary encoder with a presence flag and a multi-hot flag.
// The index is only meaningful when exactly one bit is set.
module ps_onehot_enc #(
   parameter int WIDTH = 16,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] onehot,
   output logic [IDX_W-1:0] idx,
   output logic             any,
   output logic             multi
);

   // OR together the indices of all set bits and flag a second set bit
   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
      idx   = '0;
      any   = 1'b0;
      multi = 1'b0;
      for (int k = 0; k < WIDTH; k++) begin
         if (onehot[k]) begin
            if (any) begin
               multi = 1'b1;
            end
            any = 1'b1;
            idx = idx | IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/ps_issue_reg.sv
// Issue register downstream of the RS priority selector. Captures the
// granted slot into a single-entry register, hands it to the FUs with a
// valid/ready handshake, frees the RS slot only when the grant is taken,
// and feeds back a registered ALU stall to the selector.
module ps_issue_reg
   import ps_issue_reg_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int DATA_W = 64,
   parameter int CNT_W  = 16
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [WIDTH-1:0]          gnt,
   input  FUNC_UNIT                  func_in,
   input  logic [WIDTH*DATA_W-1:0]   slot_data,
   input  logic [NUM_FU_CLASS-1:0]   fu_ready,
   input  logic                      squash,
   output logic [WIDTH-1:0]          rs_clear,
   output logic                      issue_valid,
   output FUNC_UNIT                  issue_func,
   output logic [$clog2(WIDTH)-1:0]  issue_idx,
   output logic [DATA_W-1:0]         issue_data,
   output logic                      ALU0_stall_out,
   output logic [CNT_W-1:0]          issued_cnt,
   output logic                      gnt_err
);

   localparam int IDX_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [IDX_W-1:0]  gnt_idx;
   logic              gnt_any;
   logic              gnt_multi;
   logic [DATA_W-1:0] gnt_data;
   logic              fire;
   logic              accept;
   logic              hold_presented;
   logic              stall_next;

   ps_onehot_enc #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
   ) u_enc (
      .onehot (gnt),
      .idx    (gnt_idx),
      .any    (gnt_any),
      .multi  (gnt_multi)
   );

   // AND-OR payload mux: the granted slot's payload, zero when no grant
   always_comb begin
      gnt_data = '0;
      for (int k = 0; k < WIDTH; k++) begin
         gnt_data = gnt_data | (slot_data[k*DATA_W +: DATA_W] & {DATA_W{gnt[k]}});
      end
   end

   // Handshake: fire drains the register, accept refills it (possibly same cycle)
   always_comb begin
      fire   = issue_valid & fu_ready[issue_func];
      accept = gnt_any & ~gnt_multi & ~squash & (~issue_valid | fire);
      // A slot is freed only when its grant is taken; nothing is freed during reset.
      rs_clear = (accept & reset_n) ? gnt : '0;
      // The held op stays put next cycle: presented, not taken, not replaced.
      hold_presented = issue_valid & ~fire & ~accept;
      // On a hold the next func is the current one, so only an ALU hold stalls.
      stall_next = ~squash & hold_presented & (issue_func == ALU);
   end

   // Issue register with squash > accept > fire > hold priority
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         issue_valid <= 1'b0;
         issue_func  <= ALU;
         issue_idx   <= '0;
         // NOTE: the payload is reset even though it is qualified by issue_valid, so it never shows X downstream.
         issue_data  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values of its neighbours.
         if (squash) begin
            issue_valid <= 1'b0;
         end else if (accept) begin
            issue_valid <= 1'b1;
            issue_func  <= func_in;
            issue_idx   <= gnt_idx;
            issue_data  <= gnt_data;
         end else if (fire) begin
            issue_valid <= 1'b0;
         end
      end
   end

   // Status: registered ALU stall, saturating issue count, sticky grant error
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ALU0_stall_out <= 1'b0;
         issued_cnt     <= '0;
         gnt_err        <= 1'b0;
      end else begin
         ALU0_stall_out <= stall_next;
         if (fire && !squash && (issued_cnt != CNT_MAX)) begin
            issued_cnt <= issued_cnt + CNT_W'(1);
         end
         if (gnt_multi) begin
            gnt_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ps_issue_reg.sv
// Self-checking bench for ps_issue_reg: directed scenarios followed by a
// random phase, all compared against a behavioural model of the issue slot.
// A second instance with a 2-bit counter sees the same stimulus to exercise
// counter saturation.
module tb_ps_issue_reg;
   import ps_issue_reg_pkg::*;

   localparam int WIDTH  = 16;
   localparam int DATA_W = 64;

   logic                    clock;
   logic                    reset_n;
   logic [WIDTH-1:0]        gnt;
   FUNC_UNIT                func_in;
   logic [WIDTH*DATA_W-1:0] slot_data;
   logic [3:0]              fu_ready;
   logic                    squash;

   logic [WIDTH-1:0]  rs_clear;
   logic              issue_valid;
   FUNC_UNIT          issue_func;
   logic [3:0]        issue_idx;
   logic [DATA_W-1:0] issue_data;
   logic              ALU0_stall_out;
   logic [15:0]       issued_cnt;
   logic              gnt_err;

   logic [WIDTH-1:0]  s_rs_clear;
   logic              s_issue_valid;
   FUNC_UNIT          s_issue_func;
   logic [3:0]        s_issue_idx;
   logic [DATA_W-1:0] s_issue_data;
   logic              s_stall;
   logic [1:0]        s_issued_cnt;
   logic              s_gnt_err;

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model of the one-entry issue slot
   bit          m_valid;
   FUNC_UNIT    m_func;
   int          m_idx;
   logic [63:0] m_data;
   bit          m_stall;
   int          m_fires;
   bit          m_err;
   logic [63:0] payload [WIDTH];

   ps_issue_reg #(.WIDTH(WIDTH), .DATA_W(DATA_W), .CNT_W(16)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .gnt            (gnt),
      .func_in        (func_in),
      .slot_data      (slot_data),
      .fu_ready       (fu_ready),
      .squash         (squash),
      .rs_clear       (rs_clear),
      .issue_valid    (issue_valid),
      .issue_func     (issue_func),
      .issue_idx      (issue_idx),
      .issue_data     (issue_data),
      .ALU0_stall_out (ALU0_stall_out),
      .issued_cnt     (issued_cnt),
      .gnt_err        (gnt_err)
   );

   ps_issue_reg #(.WIDTH(WIDTH), .DATA_W(DATA_W), .CNT_W(2)) dut_sat (
      .clock          (clock),
      .reset_n        (reset_n),
      .gnt            (gnt),
      .func_in        (func_in),
      .slot_data      (slot_data),
      .fu_ready       (fu_ready),
      .squash         (squash),
      .rs_clear       (s_rs_clear),
      .issue_valid    (s_issue_valid),
      .issue_func     (s_issue_func),
      .issue_idx      (s_issue_idx),
      .issue_data     (s_issue_data),
      .ALU0_stall_out (s_stall),
      .issued_cnt     (s_issued_cnt),
      .gnt_err        (s_gnt_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_func  = ALU;
      m_idx   = 0;
      m_data  = '0;
      m_stall = 1'b0;
      m_fires = 0;
      m_err   = 1'b0;
   endtask

   task automatic pack_slots();
      for (int k = 0; k < WIDTH; k++) slot_data[k*DATA_W +: DATA_W] = payload[k];
   endtask

   // Compare all registered outputs of both instances with the model
   task automatic check_regs();
      chk("issue_valid", 64'(issue_valid), 64'(m_valid));
      chk("issue_func", 64'(issue_func), 64'(m_func));
      chk("issue_idx", 64'(issue_idx), 64'(m_idx));
      chk("issue_data", issue_data, m_data);
      chk("alu0_stall", 64'(ALU0_stall_out), 64'(m_stall));
      chk("issued_cnt", 64'(issued_cnt), 64'((m_fires > 65535) ? 65535 : m_fires));
      chk("gnt_err", 64'(gnt_err), 64'(m_err));
      chk("sat_cnt", 64'(s_issued_cnt), 64'((m_fires > 3) ? 3 : m_fires));
      chk("sat_valid", 64'(s_issue_valid), 64'(m_valid));
   endtask

   // One clock cycle: drive, check, advance the model across the edge
   task automatic cycle(input logic [15:0] g, input FUNC_UNIT f, input logic [3:0] r, input logic s);
      int  ones;
      bit  fire;
      bit  accept;
      int  gi;
      @(negedge clock);
      gnt = g; func_in = f; fu_ready = r; squash = s;
      pack_slots();
      #1;
      check_regs();
      ones   = $countones(g);
      fire   = m_valid && r[m_func];
      accept = (ones == 1) && !s && (!m_valid || fire);
      chk("rs_clear", 64'(rs_clear), 64'(accept ? g : 16'h0));
      if (ones > 1) m_err = 1'b1;
      if (fire && !s) m_fires++;
      // An ALU op left waiting (not taken, not squashed) raises the stall one cycle later.
      m_stall = !s && m_valid && !fire && (m_func == ALU);
      if (s) begin
         m_valid = 1'b0;
      end else if (accept) begin
         gi = 0;
         for (int i = 0; i < WIDTH; i++) if (g[i]) gi = i;
         m_valid = 1'b1;
         m_func  = f;
         m_idx   = gi;
         m_data  = payload[gi];
      end else if (fire) begin
         m_valid = 1'b0;
      end
   endtask

   initial begin
      logic [15:0] rg;
      int          sel;
      int          a;
      int          b;

      reset_n  = 1'b0;
      gnt      = '0;
      func_in  = ALU;
      fu_ready = 4'h0;
      squash   = 1'b0;
      for (int k = 0; k < WIDTH; k++) payload[k] = {$urandom, $urandom};
      pack_slots();
      model_reset();
      #12;
      chk("reset_clear", 64'(rs_clear), 64'h0);
      @(negedge clock);
      reset_n = 1'b1;

      // Idle cycle: reset state
      cycle(16'h0000, ALU, 4'hF, 1'b0);

      // Single grant of slot 4 (MULT), all FUs ready; fires the next cycle
      cycle(16'h0010, MULT, 4'hF, 1'b0);
      cycle(16'h0000, ALU, 4'hF, 1'b0);
      cycle(16'h0000, ALU, 4'hF, 1'b0);

      // Back-to-back: slot 2 then slot 7
      cycle(16'h0004, LOAD, 4'hF, 1'b0);
      cycle(16'h0080, BRANCH, 4'hF, 1'b0);
      cycle(16'h0000, ALU, 4'hF, 1'b0);
      cycle(16'h0000, ALU, 4'hF, 1'b0);

      // ALU backpressure; MULT slot 9 refused while full
      cycle(16'h0008, ALU, 4'hF, 1'b0);
      cycle(16'h0000, ALU, 4'hE, 1'b0);
      cycle(16'h0200, MULT, 4'hE, 1'b0);
      cycle(16'h0000, ALU, 4'hE, 1'b0);
      cycle(16'h0000, ALU, 4'hF, 1'b0);
      cycle(16'h0000, ALU, 4'hF, 1'b0);

      // Squash with a coincident grant of slot 0
      cycle(16'h0020, ALU, 4'hF, 1'b0);
      cycle(16'h0001, ALU, 4'h0, 1'b1);
      cycle(16'h0000, ALU, 4'h0, 1'b0);

      // Multi-hot grant: refused, sticky error
      cycle(16'h0003, MULT, 4'hF, 1'b0);
      cycle(16'h0000, ALU, 4'hF, 1'b0);

      // Fifth fire, then hold an ALU op ahead of the mid-operation reset
      cycle(16'h0040, LOAD, 4'hF, 1'b0);
      cycle(16'h0000, ALU, 4'hF, 1'b0);
      cycle(16'h0400, ALU, 4'hE, 1'b0);
      cycle(16'h0000, ALU, 4'hE, 1'b0);

      // Reset between edges with an op held and five fires counted
      @(negedge clock);
      gnt = 16'h0100; func_in = MULT; fu_ready = 4'hF; squash = 1'b0;
      #1;
      chk("pre_rst_valid", 64'(issue_valid), 64'h1);
      chk("pre_rst_cnt", 64'(issued_cnt), 64'd5);
      #1 reset_n = 1'b0;
      #1;
      chk("rst_valid", 64'(issue_valid), 64'h0);
      chk("rst_func", 64'(issue_func), 64'(ALU));
      chk("rst_idx", 64'(issue_idx), 64'h0);
      chk("rst_data", issue_data, 64'h0);
      chk("rst_stall", 64'(ALU0_stall_out), 64'h0);
      chk("rst_cnt", 64'(issued_cnt), 64'h0);
      chk("rst_err", 64'(gnt_err), 64'h0);
      chk("rst_clear", 64'(rs_clear), 64'h0);
      chk("rst_sat_cnt", 64'(s_issued_cnt), 64'h0);
      model_reset();
      @(negedge clock);
      gnt = '0;
      reset_n = 1'b1;

      // Random phase
      for (int n = 0; n < 500; n++) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 3) begin
            rg = 16'h0000;
         end else if (sel < 9) begin
            rg = 16'h0001 << $urandom_range(0, 15);
         end else begin
            a  = int'($urandom_range(0, 15));
            b  = (a + int'($urandom_range(1, 15))) % 16;
            rg = (16'h0001 << a) | (16'h0001 << b);
         end
         payload[$urandom_range(0, 15)] = {$urandom, $urandom};
         cycle(rg, FUNC_UNIT'($urandom_range(0, 3)), 4'($urandom),
               ($urandom_range(0, 15) == 0));
      end
      cycle(16'h0000, ALU, 4'hF, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
